// File: rtl/z_pc.sv
// Next-PC unit: combinational next_pc (jump / branch / sequential) plus a registered copy pc_q.
// Optional macro Z_PC_BNE_EN adds bne decode (opcode 6'b000101 branches on ~zero).
module z_pc #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned PC_STEP      = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   input  logic [31:0] inst,
   input  logic        jump,
   input  logic        branch,
   input  logic        zero,
   output logic [31:0] next_pc,
   output logic [31:0] pc_q
);

   localparam int unsigned PC_W     = 32;
   localparam int unsigned IMM_W    = 16;
   localparam int unsigned OPCODE_W = 6;

   logic [PC_W-1:0] pc_plus4;
   logic [PC_W-1:0] imm_ext;
   logic [PC_W-1:0] branch_target;
   logic [PC_W-1:0] jump_target;
   logic            take_branch;

   assign pc_plus4      = pc + PC_W'(PC_STEP);
   assign imm_ext       = {{(PC_W-IMM_W){inst[IMM_W-1]}}, inst[IMM_W-1:0]};
   assign branch_target = pc_plus4 + (imm_ext << 2);
   assign jump_target   = {pc_plus4[31:28], inst[25:0], 2'b00};

`ifdef Z_PC_BNE_EN
   localparam logic [OPCODE_W-1:0] OPC_BNE = 6'b000101;

   // bne inverts the sense of the ALU zero flag; every other opcode branches on equal.
   always_comb begin
      take_branch = branch & zero;
      if (inst[31:26] == OPC_BNE) begin
         take_branch = branch & ~zero;
      end
   end
`else
   logic [OPCODE_W-1:0] unused_opcode;

   assign unused_opcode = inst[31:26];
   assign take_branch   = branch & zero;
`endif

   // Jump has priority over a taken branch, which has priority over sequential fetch.
   always_comb begin
      next_pc = pc_plus4;
      if (jump) begin
         next_pc = jump_target;
      end else if (take_branch) begin
         next_pc = branch_target;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_VECTOR;
      end else begin
         pc_q <= next_pc;
      end
   end

endmodule

// File: tb/tb_z_pc.sv
// Self-checking bench for z_pc: directed cases plus randomized stimulus against an arithmetic model.
module tb_z_pc;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic [31:0] inst;
   logic        jump;
   logic        branch;
   logic        zero;
   logic [31:0] next_pc;
   logic [31:0] pc_q;

   int checks = 0;
   int errors = 0;

   z_pc dut (
      .clk     (clk),
      .rst     (rst),
      .pc      (pc),
      .inst    (inst),
      .jump    (jump),
      .branch  (branch),
      .zero    (zero),
      .next_pc (next_pc),
      .pc_q    (pc_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // Reference: next address computed from the instruction-set rules with plain arithmetic.
   function automatic logic [31:0] model(input logic [31:0] pc_v, input logic [31:0] inst_v,
                                         input logic j, input logic b, input logic z);
      logic [31:0] seq;
      logic [31:0] tgt_b;
      logic [31:0] tgt_j;
      int          offset;
      logic        cond;
      logic [5:0]  opc;
      seq    = pc_v + 32'd4;
      offset = int'($signed(inst_v[15:0])) * 4;
      tgt_b  = seq + 32'(offset);
      tgt_j  = (seq & 32'hF000_0000) | ((inst_v & 32'h03FF_FFFF) << 2);
      opc    = inst_v[31:26];
      cond   = z;
`ifdef Z_PC_BNE_EN
      if (opc == 6'd5) cond = ~z;
`else
      if (opc == 6'd5) cond = z;
`endif
      if (j)              return tgt_j;
      else if (b && cond) return tgt_b;
      else                return seq;
   endfunction

   task automatic apply(input logic [31:0] p, input logic [31:0] i,
                        input logic j, input logic b, input logic z);
      pc = p; inst = i; jump = j; branch = b; zero = z;
      #1;
   endtask

   initial begin
      logic [31:0] exp_nx;
      rst = 1'b1;
      apply(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      check("reset_pc_q", pc_q, 32'h0);
      apply(32'h0000_0010, 32'h0, 1'b0, 1'b0, 1'b0);
      check("next_pc_in_reset", next_pc, 32'h0000_0014);
      @(negedge clk);
      rst = 1'b0;

      // Directed cases
      apply(32'h0, 32'h5555_5555, 1'b0, 1'b1, 1'b1);
      check("branch_taken", next_pc, 32'h0001_5558);
      @(posedge clk); #1;
      check("branch_taken_pc_q", pc_q, 32'h0001_5558);

      apply(32'h0, 32'h5555_5555, 1'b1, 1'b1, 1'b1);
      check("jump_priority", next_pc, 32'h0555_5554);
      apply(32'h0040_0000, 32'h5555_5555, 1'b0, 1'b1, 1'b0);
      check("seq_not_taken", next_pc, 32'h0040_0004);
      apply(32'hFFFF_FFFC, 32'h5555_5555, 1'b0, 1'b0, 1'b1);
      check("seq_wrap", next_pc, 32'h0000_0000);
      apply(32'h0000_0100, 32'h1000_FFFF, 1'b0, 1'b1, 1'b1);
      check("neg_offset", next_pc, 32'h0000_0100);
      apply(32'hF000_0000, 32'h03FF_FFFF, 1'b1, 1'b0, 1'b0);
      check("jump_region", next_pc, 32'hFFFF_FFFC);

      // Asynchronous reset in mid-cycle, held through edges
      apply(32'h0, 32'h5555_5555, 1'b0, 1'b1, 1'b1);
      @(posedge clk); #1;
      check("pre_reset_pc_q", pc_q, 32'h0001_5558);
      #2 rst = 1'b1;
      #1 check("async_reset", pc_q, 32'h0);
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         check("reset_hold", pc_q, 32'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      apply(32'h0040_0000, 32'h5555_5555, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("post_reset_load", pc_q, 32'h0040_0004);

      // bne decode
      apply(32'h0, 32'h1400_0002, 1'b0, 1'b1, 1'b0);
`ifdef Z_PC_BNE_EN
      check("bne_zero0", next_pc, 32'h0000_000C);
`else
      check("bne_zero0", next_pc, 32'h0000_0004);
`endif
      apply(32'h0, 32'h1400_0002, 1'b0, 1'b1, 1'b1);
`ifdef Z_PC_BNE_EN
      check("bne_zero1", next_pc, 32'h0000_0004);
`else
      check("bne_zero1", next_pc, 32'h0000_000C);
`endif

      // Randomized stimulus against the model
      for (int n = 0; n < 300; n++) begin
         logic [31:0] rp;
         logic [31:0] ri;
         rp = $urandom();
         ri = $urandom();
         if ($urandom_range(0, 3) == 0) ri[31:26] = 6'd5;
         if ($urandom_range(0, 7) == 0) rp = 32'hFFFF_FFFC;
         apply(rp, ri, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
         exp_nx = model(pc, inst, jump, branch, zero);
         check("rand_next_pc", next_pc, exp_nx);
         @(posedge clk); #1;
         check("rand_pc_q", pc_q, exp_nx);
         if ($urandom_range(0, 15) == 0) begin
            rst = 1'b1;
            #1 check("rand_async_reset", pc_q, 32'h0);
            rst = 1'b0;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/z_pc.md
Name: z_pc

Overview:
- Next-program-counter unit for the single-cycle MIPS-style datapath.
- Computes next_pc combinationally from the current pc, the fetched instruction and the control/ALU flags (jump, branch, zero).
- Also holds a registered copy of the selected address (pc_q) so it can drive the fetch address directly.
- Sits between the control unit/ALU and the instruction memory address port.

Parameters:
- RESET_VECTOR, 32'h0000_0000, value loaded into pc_q on reset.
- PC_STEP, 4, byte increment for sequential fetch.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- pc  input  32  current program counter (byte address)
- inst  input  32  current instruction word
- jump  input  1  control: unconditional J-type jump
- branch  input  1  control: conditional branch instruction
- zero  input  1  ALU zero flag for the branch compare
- next_pc  output  32  combinational next address
- pc_q  output  32  registered next_pc

Interface note: one clock; reset is asynchronous and active-high.

Behaviour:
- pc_plus4 = pc + PC_STEP, modulo 2^32; 0xFFFFFFFC wraps to 0x00000000.
- imm_ext = sign-extend inst[15:0] to 32 bits.
- branch_target = pc_plus4 + (imm_ext << 2), modulo 2^32.
- jump_target = {pc_plus4[31:28], inst[25:0], 2'b00}.
- take_branch = branch & zero, in the base build.
- Selection priority:
  - jump = 1 -> jump_target, regardless of branch and zero.
  - otherwise take_branch = 1 -> branch_target.
  - otherwise -> pc_plus4.
- next_pc is purely combinational: zero latency from any input change, no state.
- pc_q:
  - Loads next_pc on every rising clk edge.
  - rst asserted -> pc_q = RESET_VECTOR immediately, independent of clk, and held while rst is high.
  - First edge after rst deasserts loads next_pc.
- next_pc does not depend on rst; it is valid while reset is asserted.
- X/Z on jump or branch is not supported; inputs must be driven 0 or 1.
- inst fields are decoded only as listed above; no other opcode checking in the base build.

Optional Feature:
- Macro: Z_PC_BNE_EN.
- When defined, the opcode inst[31:26] is decoded:
  - opcode 6'b000101 (bne): take_branch = branch & ~zero.
  - all other opcodes: take_branch = branch & zero.
- When undefined, take_branch = branch & zero for every opcode.
- Priority, targets and pc_q behaviour are identical in both builds.

Test Plan:
- Branch taken: pc=0, inst=0x55555555, jump=0, branch=1, zero=1 -> next_pc=0x00015558; after one clk edge pc_q=0x00015558.
- Jump priority: same inst, pc=0, jump=1, branch=1, zero=1 -> next_pc=0x05555554.
- Sequential fetch:
  - pc=0x00400000, branch=1, zero=0, jump=0 -> next_pc=0x00400004.
  - pc=0xFFFFFFFC, branch=0, jump=0 -> next_pc=0x00000000 (wrap).
- Negative offset: pc=0x00000100, inst=0x1000FFFF, branch=1, zero=1 -> next_pc=0x00000100.
- Reset:
  - Raise rst mid-cycle with pc_q=0x00015558 -> pc_q=0x00000000 before the next clk edge, held through clock edges while rst=1.
  - After deassert, next edge loads next_pc.
- Z_PC_BNE_EN build: pc=0, inst=0x14000002, branch=1.
  - zero=0 -> next_pc=0x0000000C.
  - zero=1 -> next_pc=0x00000004.
  - Without the macro, the same stimulus gives 0x00000004 and 0x0000000C respectively.
